// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Decimal digits needed to hold 2**width-1; 0.30103 approximates log10(2).
    function automatic int bcd_digits_for(input int width);
        longint scaled;
        scaled = longint'(width) * 64'sd30103 + 64'sd99999;
        return int'(scaled / 64'sd100000);
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with start/ready/valid
// handshake and a sticky overflow for results wider than DIGITS decimal digits.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t             state_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       bin_q;
    logic [4*DIGITS-1:0]    acc_q;
    logic                   sticky_q;
    logic                   ready_q;
    logic                   valid_q;
    logic [4*DIGITS-1:0]    bcd_out_q;
    logic                   overflow_q;

    logic [4*DIGITS-1:0]    acc_adj;
    logic [4*DIGITS-1:0]    acc_d;
    logic [WIDTH-1:0]       bin_d;
    logic                   sticky_d;
    logic                   last_step;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_digit u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    // A bit leaving the top digit is a carry of 10**DIGITS; dropping it keeps the result modulo.
    always_comb begin
        acc_d     = {acc_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_d     = bin_q << 1;
        sticky_d  = sticky_q | acc_adj[4*DIGITS-1];
        last_step = (cnt_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q    <= bin_in;
                        acc_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= CW'(WIDTH);
                        ready_q  <= 1'b0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q    <= acc_d;
                    bin_q    <= bin_d;
                    sticky_q <= sticky_d;
                    cnt_q    <= cnt_q - CW'(1);
                    if (last_step) begin
                        bcd_out_q  <= acc_d;
                        overflow_q <= sticky_d;
                        valid_q    <= 1'b1;
                        ready_q    <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign valid    = valid_q;
    assign bcd_out  = bcd_out_q;
    assign overflow = overflow_q;

endmodule
